// File: rtl/heap_pkg.sv
// Shared types for the heap command front-end.
// Ops, status codes, FSM states and default widths.
package heap_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int CNT_W_DEF = 10;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_OVERFLOW  = 2'd1,
    ST_UNDERFLOW = 2'd2,
    ST_TIMEOUT   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/heap_cmd_fifo.sv
// Synchronous show-ahead FIFO of {op, key} commands.
// Ports: wr_en/wr_data in, rd_en/rd_data out, full/empty/count status.
module heap_cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // No write while full, even with a read in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == FULL_N);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)
        count <= count + 1'b1;
      else if (do_rd && !do_wr)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/heap_cmd_sequencer.sv
// Buffers push/pop commands and issues them one at a time to heap_control.
// Ports: cmd stream in, heap start/op/key/done/n, rsp stream out, busy/count.
module heap_cmd_sequencer
  import heap_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CAPACITY = 1023,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [KEY_W-1:0]       cmd_key,
  output logic                   heap_start,
  output logic                   heap_op,
  output logic [KEY_W-1:0]       heap_key,
  input  logic                   heap_done,
  input  logic [CNT_W-1:0]       heap_n,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_op,
  output logic [1:0]             rsp_status,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CAP_N   = CNT_W'(CAPACITY);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic               op_q;
  logic [KEY_W-1:0]   key_q;
  logic [WD_W-1:0]    wd_q;
  logic               wd_clr, wd_inc;
  logic               fifo_rd, fifo_full, fifo_empty;
  logic [KEY_W:0]     fifo_rd_data;
  logic               issuing;

  heap_cmd_fifo #(
    .W     (KEY_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_op, cmd_key}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    fifo_rd    = 1'b0;
    heap_start = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q == OP_PUSH && heap_n >= CAP_N) begin
          status_d = ST_OVERFLOW;
          state_d  = S_RESP;
        end else if (op_q == OP_POP && heap_n == '0) begin
          status_d = ST_UNDERFLOW;
          state_d  = S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        heap_start = 1'b1;
        wd_clr     = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (heap_done) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (wd_q == WD_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      op_q     <= 1'b0;
      key_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (fifo_rd) {op_q, key_q} <= fifo_rd_data;
      if (wd_clr)
        wd_q <= '0;
      else if (wd_inc)
        wd_q <= wd_q + 1'b1;
    end
  end

  // Heap-facing op/key only carry the command while it is in flight.
  assign issuing    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign heap_op    = issuing ? op_q : 1'b0;
  assign heap_key   = issuing ? key_q : '0;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_op     = rsp_valid ? op_q : 1'b0;
  assign rsp_status = rsp_valid ? status_q : ST_OK;

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule
